// File: rtl/sitcp_stream_pkg.sv
// Shared encodings for the SiTCP TCP stream engine: session modes, FSM
// states and the TCP_RX_WC padding helper.
package sitcp_stream_pkg;

  typedef enum logic [1:0] {
    MODE_LOOP  = 2'b00,
    MODE_GEN_B = 2'b01,
    MODE_SINK  = 2'b10,
    MODE_GEN_W = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ACTIVE  = 2'b01,
    ST_CLOSING = 2'b10
  } state_e;

  // Number of forced-one bits above the FIFO fill field in TCP_RX_WC.
  function automatic int wc_pad_w(input int wc_w, input int fifo_aw);
    return wc_w - fifo_aw - 1;
  endfunction

endpackage

// File: rtl/sitcp_sync_fifo.sv
// Byte-wide synchronous FIFO, depth 2**FIFO_AW, with synchronous flush.
// A written byte becomes readable one edge after it is written (empty is
// judged against a delayed copy of the write pointer); fill and full track
// the true occupancy so overflow is detected without delay.
module sitcp_sync_fifo #(
  parameter int FIFO_AW = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [7:0]       din,
  input  logic             rd_en,
  output logic [7:0]       dout,
  output logic             empty,
  output logic             full,
  output logic [FIFO_AW:0] fill
);

  localparam int DEPTH = 1 << FIFO_AW;

  logic [7:0]       r_mem [0:DEPTH-1];
  logic [FIFO_AW:0] r_wp;
  logic [FIFO_AW:0] r_rp;
  logic [FIFO_AW:0] r_wp_vis;

  assign dout  = r_mem[r_rp[FIFO_AW-1:0]];
  assign fill  = r_wp - r_rp;
  // fill never exceeds DEPTH, so its top bit is set only when full.
  assign full  = fill[FIFO_AW];
  assign empty = (r_rp == r_wp_vis);

  // Storage write; contents need no reset because pointers gate all reads.
  always_ff @(posedge clk) begin
    if (wr_en && !full) r_mem[r_wp[FIFO_AW-1:0]] <= din;
  end

  // Pointer update: flush wins, otherwise independent write and read sides.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp     <= '0;
      r_rp     <= '0;
      r_wp_vis <= '0;
    end else if (flush) begin
      r_wp     <= '0;
      r_rp     <= '0;
      r_wp_vis <= '0;
    end else begin
      if (wr_en && !full) r_wp <= r_wp + (FIFO_AW+1)'(1);
      if (rd_en && !empty) r_rp <= r_rp + (FIFO_AW+1)'(1);
      r_wp_vis <= r_wp;
    end
  end

endmodule

// File: rtl/sitcp_tcp_stream_engine.sv
// SiTCP TCP stream engine: session FSM with close handshake, and a datapath
// that loops rx bytes back through a FIFO, sinks them, or generates a byte /
// 32-bit word pattern. Per-session counters and flags stay readable after
// the session ends and clear on the next open.
module sitcp_tcp_stream_engine
  import sitcp_stream_pkg::*;
#(
  parameter int FIFO_AW = 12,
  parameter int WC_W    = 16,
  parameter int CNT_W   = 32
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic [1:0]       MODE,
  input  logic [CNT_W-1:0] GEN_LEN,
  input  logic             TCP_OPEN_ACK,
  input  logic             TCP_CLOSE_REQ,
  output logic             TCP_CLOSE_ACK,
  input  logic             TCP_RX_WR,
  input  logic [7:0]       TCP_RX_DATA,
  output logic [WC_W-1:0]  TCP_RX_WC,
  input  logic             TCP_TX_FULL,
  output logic             TCP_TX_WR,
  output logic [7:0]       TCP_TX_DATA,
  output logic [CNT_W-1:0] RX_BYTE_CNT,
  output logic [CNT_W-1:0] TX_BYTE_CNT,
  output logic             OVF_ERR,
  output logic             GEN_DONE,
  output logic [1:0]       STATE
);

  localparam int PAD_W = wc_pad_w(WC_W, FIFO_AW);
  localparam logic [WC_W-1:0] WC_PAD = {WC_W{1'b1}} << (WC_W - PAD_W);

  state_e           r_state;
  mode_e            r_mode;
  logic [CNT_W-1:0] r_gen_len;
  logic             r_close_ack;
  logic [CNT_W-1:0] r_rx_cnt;
  logic [CNT_W-1:0] r_tx_cnt;
  logic [CNT_W-1:0] r_gen_cnt;
  logic [31:0]      r_gen_word;
  logic [1:0]       r_gen_idx;
  logic             r_gen_done;
  logic             r_ovf;
  logic             r_tx_wr;
  logic [7:0]       r_tx_data;
  logic [WC_W-1:0]  r_wc;

  logic             w_open;
  logic             w_active;
  logic             w_run;
  logic             w_is_loop;
  logic             w_is_gen;
  logic             w_flush;
  logic             w_fifo_wr;
  logic             w_fifo_rd;
  logic             w_fifo_empty;
  logic             w_fifo_full;
  logic [7:0]       w_fifo_dout;
  logic [FIFO_AW:0] w_fifo_fill;
  logic             w_gen_fire;
  logic             w_tx_fire;
  logic [7:0]       w_gen_byte;

  // w_run excludes the edge on which the session is leaving ACTIVE, so no
  // tx strobe is launched into a non-ACTIVE cycle.
  assign w_open    = (r_state == ST_IDLE) && TCP_OPEN_ACK;
  assign w_active  = (r_state == ST_ACTIVE);
  assign w_run     = w_active && TCP_OPEN_ACK && !TCP_CLOSE_REQ;
  assign w_is_loop = (r_mode == MODE_LOOP);
  assign w_is_gen  = (r_mode == MODE_GEN_B) || (r_mode == MODE_GEN_W);
  assign w_flush   = !w_active;
  assign w_fifo_wr = w_active && w_is_loop && TCP_RX_WR && !w_fifo_full;
  assign w_fifo_rd = w_run && w_is_loop && !w_fifo_empty && !TCP_TX_FULL;
  assign w_gen_fire = w_run && w_is_gen && !TCP_TX_FULL && !r_gen_done;
  assign w_tx_fire = w_fifo_rd || w_gen_fire;

  assign TCP_CLOSE_ACK = r_close_ack;
  assign TCP_RX_WC     = r_wc;
  assign TCP_TX_WR     = r_tx_wr;
  assign TCP_TX_DATA   = r_tx_data;
  assign RX_BYTE_CNT   = r_rx_cnt;
  assign TX_BYTE_CNT   = r_tx_cnt;
  assign OVF_ERR       = r_ovf;
  assign GEN_DONE      = r_gen_done;
  assign STATE         = r_state;

  sitcp_sync_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
    .clk   (CLK),
    .rst_n (RSTn),
    .flush (w_flush),
    .wr_en (w_fifo_wr),
    .din   (TCP_RX_DATA),
    .rd_en (w_fifo_rd),
    .dout  (w_fifo_dout),
    .empty (w_fifo_empty),
    .full  (w_fifo_full),
    .fill  (w_fifo_fill)
  );

  // Pattern byte: low counter byte, or the current word sent MSB first.
  always_comb begin
    w_gen_byte = r_gen_cnt[7:0];
    if (r_mode == MODE_GEN_W) begin
      case (r_gen_idx)
        2'd0:    w_gen_byte = r_gen_word[31:24];
        2'd1:    w_gen_byte = r_gen_word[23:16];
        2'd2:    w_gen_byte = r_gen_word[15:8];
        default: w_gen_byte = r_gen_word[7:0];
      endcase
    end
  end

  // Session FSM, close acknowledge and per-session configuration latch.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state     <= ST_IDLE;
      r_close_ack <= 1'b0;
      r_mode      <= MODE_LOOP;
      r_gen_len   <= '0;
    end else begin
      r_close_ack <= TCP_CLOSE_REQ;
      case (r_state)
        ST_IDLE: begin
          if (TCP_OPEN_ACK) begin
            r_state   <= ST_ACTIVE;
            r_mode    <= mode_e'(MODE);
            r_gen_len <= GEN_LEN;
          end
        end
        ST_ACTIVE: begin
          if (TCP_CLOSE_REQ)     r_state <= ST_CLOSING;
          else if (!TCP_OPEN_ACK) r_state <= ST_IDLE;
        end
        ST_CLOSING: begin
          if (!TCP_CLOSE_REQ && !TCP_OPEN_ACK) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Datapath: tx launch, generator state, counters, flags and fill report.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_wc       <= WC_PAD;
      r_tx_wr    <= 1'b0;
      r_tx_data  <= '0;
      r_rx_cnt   <= '0;
      r_tx_cnt   <= '0;
      r_gen_cnt  <= '0;
      r_gen_word <= '0;
      r_gen_idx  <= '0;
      r_gen_done <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_wc    <= WC_PAD | WC_W'(w_fifo_fill);
      r_tx_wr <= w_tx_fire;
      if (w_tx_fire) r_tx_data <= w_fifo_rd ? w_fifo_dout : w_gen_byte;
      if (w_open) begin
        r_rx_cnt   <= '0;
        r_tx_cnt   <= '0;
        r_gen_cnt  <= '0;
        r_gen_word <= '0;
        r_gen_idx  <= '0;
        r_gen_done <= 1'b0;
        r_ovf      <= 1'b0;
      end else if (w_active) begin
        if (TCP_RX_WR) r_rx_cnt <= r_rx_cnt + CNT_W'(1);
        if (TCP_RX_WR && w_is_loop && w_fifo_full) r_ovf <= 1'b1;
        if (w_tx_fire) r_tx_cnt <= r_tx_cnt + CNT_W'(1);
        if (w_gen_fire) begin
          r_gen_cnt <= r_gen_cnt + CNT_W'(1);
          r_gen_idx <= r_gen_idx + 2'd1;
          if (r_gen_idx == 2'd3) r_gen_word <= r_gen_word + 32'd1;
          if ((r_gen_len != '0) && (r_gen_cnt + CNT_W'(1) == r_gen_len))
            r_gen_done <= 1'b1;
        end
      end
    end
  end

endmodule
